// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types and constants for the pipeline hazard controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_MD_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/hazard_fwd.sv
// ============================================================================
// Module : hazard_fwd
// Brief  : Operand bypass select for one Execute source; Memory beats Writeback.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] RsE,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic                  RegWriteW,
  output logic [1:0]            ForwardE
);

  logic w_hit_m;
  logic w_hit_w;

  // Register 0 is hard-wired, so a write to it never produces a bypass.
  assign w_hit_m = RegWriteM && (RdM != '0) && (RdM == RsE);
  assign w_hit_w = RegWriteW && (RdW != '0) && (RdW == RsE);

  always_comb begin
    ForwardE = FWD_RF;
    if (w_hit_m)      ForwardE = FWD_M;
    else if (w_hit_w) ForwardE = FWD_W;
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module : hazard_ctrl
// Brief  : Stall/flush/forward control with memory-wait and mul/div-wait FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  input  logic [ADDR_WIDTH-1:0] Rs1E,
  input  logic [ADDR_WIDTH-1:0] Rs2E,
  input  logic [ADDR_WIDTH-1:0] RdE,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  LoadE,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  MemAckM,
  input  logic                  MulDivE,
  input  logic                  MdDoneE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  MdGoE,
  output logic [CNT_WIDTH-1:0]  StallCount
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic                 w_lw_stall;
  logic                 w_mem_stall;
  logic                 w_md_go;
  logic                 w_md_busy;

  hazard_fwd #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_a (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .RdW       (RdW),
    .RegWriteW (RegWriteW),
    .ForwardE  (ForwardAE)
  );

  hazard_fwd #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_b (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .RdW       (RdW),
    .RegWriteW (RegWriteW),
    .ForwardE  (ForwardBE)
  );

  assign w_lw_stall  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
  assign w_mem_stall = MemReqM && !MemAckM;

  // A start is only issued from IDLE once memory is not holding the pipe.
  assign w_md_go   = !rst && (r_state == S_IDLE) && MulDivE && !w_mem_stall;
  assign w_md_busy = w_md_go || ((r_state == S_MD_WAIT) && !MdDoneE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (StallF && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mem_stall)  w_state_nxt = S_MEM_WAIT;
        else if (MulDivE) w_state_nxt = S_MD_WAIT;
      end
      S_MEM_WAIT: if (MemAckM) w_state_nxt = S_IDLE;
      S_MD_WAIT:  if (MdDoneE) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (w_md_busy) begin
      // Memory drains into a bubble while Execute holds the mul/div op.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      StallF = w_lw_stall;
      StallD = w_lw_stall;
      FlushE = w_lw_stall || PCSrcE;
      FlushD = PCSrcE && !w_lw_stall;
    end
  end

  assign MdGoE      = w_md_go;
  assign StallCount = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Directed self-checking bench for hazard_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, LoadE, PCSrcE;
  logic          MemReqM, MemAckM, MulDivE, MdDoneE;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushM, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          MdGoE;
  logic [CW-1:0] StallCount;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .LoadE      (LoadE),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemAckM    (MemAckM),
    .MulDivE    (MulDivE),
    .MdDoneE    (MdDoneE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushM     (FlushM),
    .FlushW     (FlushW),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .MdGoE      (MdGoE),
    .StallCount (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stall/flush vector packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
  function automatic logic [31:0] ctl();
    return {24'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};
  endfunction

  function automatic logic [31:0] st();
    return {30'd0, dut.r_state};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemAckM, MulDivE, MdDoneE} = '0;
    tick();
    tick();
    chk("reset_count", 32'(StallCount), 32'd0);
    chk("reset_state", st(), 32'(S_IDLE));
    chk("reset_ctl", ctl(), 32'h00);
    chk("reset_go", 32'(MdGoE), 32'd0);
    rst = 1'b0;

    // Forwarding
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd3;
    settle();
    chk("fwd_a_mem", 32'(ForwardAE), 32'(FWD_M));
    chk("fwd_b_none", 32'(ForwardBE), 32'(FWD_RF));
    RdM = 5'd0; Rs2E = 5'd5;
    settle();
    chk("fwd_a_wb", 32'(ForwardAE), 32'(FWD_W));
    chk("fwd_b_wb", 32'(ForwardBE), 32'(FWD_W));
    RdM = 5'd5; RegWriteM = 1'b0; RegWriteW = 1'b0;
    settle();
    chk("fwd_a_nowr", 32'(ForwardAE), 32'(FWD_RF));
    RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;

    // Load-use stall
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    settle();
    chk("lw_ctl", ctl(), 32'hC4);
    tick();
    chk("lw_count", 32'(StallCount), 32'd1);
    RdE = 5'd0; Rs2D = 5'd0;
    settle();
    chk("lw_rd0_ctl", ctl(), 32'h00);
    RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    settle();
    chk("lw_branch_ctl", ctl(), 32'h0C);
    tick();
    chk("branch_count", 32'(StallCount), 32'd1);
    LoadE = 1'b0; RdE = 5'd0; Rs2D = 5'd0;
    settle();
    chk("branch_ctl", ctl(), 32'h0C);
    PCSrcE = 1'b0;

    // Memory wait: request held 4 cycles, ack in the 4th
    MemReqM = 1'b1;
    settle();
    chk("mem_c1_ctl", ctl(), 32'hF1);
    tick();
    chk("mem_c2_state", st(), 32'(S_MEM_WAIT));
    chk("mem_c2_ctl", ctl(), 32'hF1);
    tick();
    chk("mem_c3_state", st(), 32'(S_MEM_WAIT));
    tick();
    MemAckM = 1'b1;
    settle();
    chk("mem_c4_state", st(), 32'(S_MEM_WAIT));
    chk("mem_c4_ctl", ctl(), 32'h00);
    tick();
    chk("mem_done_state", st(), 32'(S_IDLE));
    chk("mem_count", 32'(StallCount), 32'd4);
    MemReqM = 1'b0; MemAckM = 1'b0;

    // Mul/div held off by memory stall
    MulDivE = 1'b1; MemReqM = 1'b1;
    settle();
    chk("md_held_go1", 32'(MdGoE), 32'd0);
    chk("md_held_ctl1", ctl(), 32'hF1);
    tick();
    chk("md_held_go2", 32'(MdGoE), 32'd0);
    tick();
    MemAckM = 1'b1;
    settle();
    chk("md_ack_go", 32'(MdGoE), 32'd0);
    tick();
    MemReqM = 1'b0; MemAckM = 1'b0;
    settle();
    chk("md_go_pulse", 32'(MdGoE), 32'd1);
    chk("md_go_ctl", ctl(), 32'hE2);
    tick();
    chk("md_wait_state", st(), 32'(S_MD_WAIT));
    chk("md_wait_go", 32'(MdGoE), 32'd0);
    chk("md_wait_ctl", ctl(), 32'hE2);
    tick();
    MdDoneE = 1'b1;
    settle();
    chk("md_done_ctl", ctl(), 32'h00);
    chk("md_done_go", 32'(MdGoE), 32'd0);
    MulDivE = 1'b0;
    tick();
    chk("md_idle_state", st(), 32'(S_IDLE));
    chk("md_count", 32'(StallCount), 32'd8);
    tick();
    chk("md_done_ignored", st(), 32'(S_IDLE));
    chk("md_done_idle_ctl", ctl(), 32'h00);
    MdDoneE = 1'b0;

    // Reset aborts a pending mul/div wait
    MulDivE = 1'b1;
    tick();
    MulDivE = 1'b0;
    settle();
    chk("rst_pre_state", st(), 32'(S_MD_WAIT));
    rst = 1'b1; MulDivE = 1'b1;
    settle();
    chk("rst_go_masked", 32'(MdGoE), 32'd0);
    tick();
    chk("rst_state", st(), 32'(S_IDLE));
    chk("rst_count", 32'(StallCount), 32'd0);
    settle();
    chk("rst_idle_go_masked", 32'(MdGoE), 32'd0);
    tick();
    rst = 1'b0; MulDivE = 1'b0;

    // Counter saturation
    MemReqM = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    chk("sat_count", 32'(StallCount), 32'hF);
    tick();
    chk("sat_hold", 32'(StallCount), 32'hF);
    MemReqM = 1'b0; MemAckM = 1'b1;
    tick();
    MemAckM = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, 5, register-address width.
REQ-002 Parameter: CNT_WIDTH, 16, stall-cycle counter width.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 Rs1D, Rs2D  input  ADDR_WIDTH  source registers in Decode.
REQ-006 Rs1E, Rs2E, RdE  input  ADDR_WIDTH  source and destination registers in Execute.
REQ-007 RdM, RdW  input  ADDR_WIDTH  destination registers in Memory and Writeback.
REQ-008 RegWriteM, RegWriteW  input  1  register-write enables in Memory and Writeback.
REQ-009 LoadE  input  1  Execute instruction is a load.
REQ-010 PCSrcE  input  1  taken branch or jump resolved in Execute.
REQ-011 MemReqM, MemAckM  input  1  Memory-stage data request (held until ack) and ack.
REQ-012 MulDivE  input  1  Execute holds an unfinished multi-cycle op.
REQ-013 MdDoneE  input  1  one-cycle completion pulse from the mul/div unit.
REQ-014 StallF, StallD, StallE, StallM  output  1  per-stage hold (pipe-register en = ~Stall).
REQ-015 FlushD, FlushE, FlushM, FlushW  output  1  per-stage sync clear (pipe-register clr).
REQ-016 ForwardAE, ForwardBE  output  2  operand select: 00 register file, 01 Writeback, 10 Memory.
REQ-017 MdGoE  output  1  one-cycle start pulse to the mul/div unit.
REQ-018 StallCount  output  CNT_WIDTH  saturating count of stall cycles.

Function
REQ-019 Forwarding SHALL be combinational: 10 if RegWriteM, RdM!=0 and RdM==Rs1E (A) or RdM==Rs2E (B); else 01 under the same test for W; else 00. Memory has priority.
REQ-020 LwStall SHALL be LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && !PCSrcE.
REQ-021 MemStall SHALL be MemReqM && !MemAckM (same-cycle, combinational).
REQ-022 FSM states: IDLE, MEM_WAIT, MD_WAIT.
REQ-023 IDLE->MEM_WAIT when MemStall; MEM_WAIT->IDLE on the cycle MemAckM is sampled high.
REQ-024 IDLE->MD_WAIT when MulDivE && !MemStall; MdGoE SHALL be 1 in that IDLE cycle only.
REQ-025 MD_WAIT->IDLE on the cycle MdDoneE is high; MdDoneE SHALL be ignored outside MD_WAIT.
REQ-026 MemStall SHALL take priority: MulDivE is held off (no MdGoE) until MemStall clears.
REQ-027 When MemStall: StallF=StallD=StallE=StallM=1, FlushW=1; FlushD=FlushE=FlushM=0.
REQ-028 When MdBusy (MD_WAIT without MdDoneE, or the MdGoE cycle): StallF=StallD=StallE=1, FlushM=1, StallM=0.
REQ-029 The MdDoneE cycle SHALL release all stalls so Execute advances with the result.
REQ-030 Otherwise: StallF=StallD=LwStall, FlushE=LwStall||PCSrcE, FlushD=PCSrcE.
REQ-031 No Flush SHALL be asserted for a stage whose Stall is asserted in the same cycle.
REQ-032 StallCount SHALL increment by 1 in every cycle StallF=1 and saturate at all-ones.

Reset
REQ-033 On rst sampled high: state=IDLE and StallCount=0; MdGoE=0 in that cycle; reset SHALL abort a pending MEM_WAIT or MD_WAIT.
REQ-034 Combinational outputs SHALL follow REQ-019..031 from inputs during and after reset.

Structure
REQ-035 Package hazard_pkg SHALL hold the state enum and the forward-select constants FWD_RF=00, FWD_W=01, FWD_M=10.
REQ-036 Forwarding SHALL be a sub-module hazard_fwd, instantiated once per operand.
REQ-037 State register and StallCount SHALL be the only flops.

Verification
REQ-038 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; RdM=0 instead -> ForwardAE=01.
REQ-039 LoadE=1, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 for one cycle, StallCount +1.
REQ-040 PCSrcE=1 -> FlushD=FlushE=1 and StallF=0.
REQ-041 MemReqM=1 for 4 cycles, with ack in the 4th -> StallM=1 and FlushW=1 for 3 cycles, state MEM_WAIT for cycles 2-4, then IDLE.
REQ-042 MulDivE=1 together with MemReqM=1 and no ack for 2 cycles -> no MdGoE until MemStall clears; then MdGoE is pulsed once, FlushM=1 each wait cycle, and the stall is released on MdDoneE.
REQ-043 rst mid-MD_WAIT -> IDLE, StallCount=0; StallCount pre-loaded to all-ones stays all-ones on a further stall.
